// File: rtl/adc_burst_averager_pkg.sv
// Shared types and constants for the ADC burst averager.
// Holds the control-state encoding and the accumulator width rule.
package adc_burst_averager_pkg;

  localparam int ADC_BITS = 14;

  typedef enum logic [2:0] {
    INIT,
    IDLE,
    TRIG,
    WAIT_LOW,
    WAIT_HIGH,
    GAP,
    DONE
  } state_e;

  // A burst of 2^sample_log2 full-scale samples fits without overflow.
  function automatic int sum_width(input int sample_log2);
    return ADC_BITS + sample_log2;
  endfunction

endpackage

// File: rtl/adc_burst_averager_if.sv
// Bundles the ADC-controller handshake and the host-side result bus.
// master = averager side, slave = controller/host side.
interface adc_burst_averager_if;
  import adc_burst_averager_pkg::*;

  logic                start;
  logic                adc_enable;
  logic                adc_reset;
  logic                adc_ready;
  logic [ADC_BITS-1:0] adc_out_a;
  logic [ADC_BITS-1:0] adc_out_b;
  logic [ADC_BITS-1:0] avg_a;
  logic [ADC_BITS-1:0] avg_b;
  logic                avg_valid;
  logic                busy;
  logic                timeout_err;

  modport master (
    input  start,
    input  adc_ready,
    input  adc_out_a,
    input  adc_out_b,
    output adc_enable,
    output adc_reset,
    output avg_a,
    output avg_b,
    output avg_valid,
    output busy,
    output timeout_err
  );

  modport slave (
    output start,
    output adc_ready,
    output adc_out_a,
    output adc_out_b,
    input  adc_enable,
    input  adc_reset,
    input  avg_a,
    input  avg_b,
    input  avg_valid,
    input  busy,
    input  timeout_err
  );

endinterface

// File: rtl/adc_accum_pair.sv
// Two-channel sample accumulator with a registered truncated average.
// The average registers only move on latch, so they hold across bursts.
module adc_accum_pair
  import adc_burst_averager_pkg::*;
#(
  parameter int SAMPLE_LOG2 = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr,
  input  logic                add,
  input  logic                latch,
  input  logic [ADC_BITS-1:0] in_a,
  input  logic [ADC_BITS-1:0] in_b,
  output logic [ADC_BITS-1:0] avg_a,
  output logic [ADC_BITS-1:0] avg_b
);

  localparam int SUM_W = sum_width(SAMPLE_LOG2);

  logic [ADC_BITS-1:0] in_v  [2];
  logic [ADC_BITS-1:0] avg_v [2];

  assign in_v[0] = in_a;
  assign in_v[1] = in_b;

  genvar gi;
  for (gi = 0; gi < 2; gi++) begin : g_chan
    logic [SUM_W-1:0]    sum_q;
    logic [SUM_W-1:0]    sum_d;
    logic [ADC_BITS-1:0] avg_q;
    logic [ADC_BITS-1:0] avg_d;

    always_comb begin
      sum_d = sum_q;
      if (clr) begin
        sum_d = '0;
      end else if (add) begin
        sum_d = sum_q + SUM_W'(in_v[gi]);
      end
      avg_d = avg_q;
      if (latch) begin
        avg_d = ADC_BITS'(sum_q >> SAMPLE_LOG2);
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sum_q <= '0;
        avg_q <= '0;
      end else begin
        sum_q <= sum_d;
        avg_q <= avg_d;
      end
    end

    assign avg_v[gi] = avg_q;
  end

  assign avg_a = avg_v[0];
  assign avg_b = avg_v[1];

endmodule

// File: rtl/adc_burst_averager.sv
// Drives the ADC readout controller through init and timed conversion bursts,
// averaging both channels and aborting to re-init if the converter stalls.
module adc_burst_averager
  import adc_burst_averager_pkg::*;
#(
  parameter int SAMPLE_LOG2 = 3,
  parameter int PERIOD      = 200,
  parameter int TIMEOUT     = 1000
) (
  input  logic CLK,
  input  logic RST_N,
  adc_burst_averager_if.master bus
);

  localparam int NSAMP   = 1 << SAMPLE_LOG2;
  localparam int CNT_W   = SAMPLE_LOG2 + 1;
  localparam int AGE_MAX = (PERIOD > TIMEOUT) ? PERIOD : TIMEOUT;
  localparam int AGE_W   = $clog2(AGE_MAX + 1);

  state_e           state_q, state_d;
  logic [1:0]       init_cnt_q, init_cnt_d;
  logic [AGE_W-1:0] age_q, age_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             adc_enable_q, adc_enable_d;
  logic             adc_reset_q, adc_reset_d;
  logic             avg_valid_q, avg_valid_d;
  logic             busy_q, busy_d;
  logic             timeout_err_q, timeout_err_d;
  logic             acc_clr, acc_add, acc_latch;

  always_comb begin
    state_d       = state_q;
    init_cnt_d    = 2'd0;
    cnt_d         = cnt_q;
    timeout_err_d = timeout_err_q;
    acc_clr       = 1'b0;
    acc_add       = 1'b0;
    acc_latch     = 1'b0;

    unique case (state_q)
      INIT: begin
        init_cnt_d = (init_cnt_q == 2'd3) ? init_cnt_q : init_cnt_q + 2'd1;
        // Ready is only trusted once our own reset pulse has finished.
        if ((init_cnt_q == 2'd3) && bus.adc_ready) begin
          state_d = IDLE;
        end
      end
      IDLE: begin
        if (bus.start && !busy_q) begin
          acc_clr       = 1'b1;
          cnt_d         = '0;
          timeout_err_d = 1'b0;
          state_d       = TRIG;
        end
      end
      TRIG: begin
        if (age_q == AGE_W'(1)) begin
          state_d = WAIT_LOW;
        end
      end
      WAIT_LOW: begin
        if (!bus.adc_ready) begin
          state_d = WAIT_HIGH;
        end else if (age_q >= AGE_W'(TIMEOUT - 1)) begin
          timeout_err_d = 1'b1;
          acc_clr       = 1'b1;
          cnt_d         = '0;
          init_cnt_d    = 2'd1;
          state_d       = INIT;
        end
      end
      WAIT_HIGH: begin
        if (bus.adc_ready) begin
          acc_add = 1'b1;
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = (cnt_d == CNT_W'(NSAMP)) ? DONE : GAP;
        end else if (age_q >= AGE_W'(TIMEOUT - 1)) begin
          timeout_err_d = 1'b1;
          acc_clr       = 1'b1;
          cnt_d         = '0;
          init_cnt_d    = 2'd1;
          state_d       = INIT;
        end
      end
      GAP: begin
        if (age_q >= AGE_W'(PERIOD - 1)) begin
          state_d = TRIG;
        end
      end
      DONE: begin
        acc_latch = 1'b1;
        state_d   = IDLE;
      end
      default: begin
        state_d = INIT;
      end
    endcase
  end

  // One age counter serves both trigger spacing and timeout: both restart at the first TRIG cycle.
  always_comb begin
    age_d = age_q;
    if ((state_d == TRIG) && (state_q != TRIG)) begin
      age_d = '0;
    end else if (age_q != AGE_W'(AGE_MAX)) begin
      age_d = age_q + AGE_W'(1);
    end
  end

  always_comb begin
    adc_enable_d = (state_d == TRIG);
    adc_reset_d  = (state_d == INIT) && ((init_cnt_d == 2'd1) || (init_cnt_d == 2'd2));
    avg_valid_d  = (state_q == DONE);
    // Keep busy through the avg_valid cycle so a coincident start is refused.
    busy_d       = (state_d != IDLE) || (state_q == DONE);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q       <= INIT;
      init_cnt_q    <= 2'd0;
      age_q         <= '0;
      cnt_q         <= '0;
      adc_enable_q  <= 1'b0;
      adc_reset_q   <= 1'b0;
      avg_valid_q   <= 1'b0;
      busy_q        <= 1'b1;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      init_cnt_q    <= init_cnt_d;
      age_q         <= age_d;
      cnt_q         <= cnt_d;
      adc_enable_q  <= adc_enable_d;
      adc_reset_q   <= adc_reset_d;
      avg_valid_q   <= avg_valid_d;
      busy_q        <= busy_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  adc_accum_pair #(
    .SAMPLE_LOG2(SAMPLE_LOG2)
  ) u_accum (
    .clk   (CLK),
    .rst_n (RST_N),
    .clr   (acc_clr),
    .add   (acc_add),
    .latch (acc_latch),
    .in_a  (bus.adc_out_a),
    .in_b  (bus.adc_out_b),
    .avg_a (bus.avg_a),
    .avg_b (bus.avg_b)
  );

  assign bus.adc_enable  = adc_enable_q;
  assign bus.adc_reset   = adc_reset_q;
  assign bus.avg_valid   = avg_valid_q;
  assign bus.busy        = busy_q;
  assign bus.timeout_err = timeout_err_q;

endmodule
